// File: rtl/iir_biquad_cascade_if.sv
// Sample stream interface for iir_biquad_cascade.
//   valid_in/data_in : producer offers a sample, taken when ready_in is high
//   ready_in         : filter is idle and can take a sample
//   valid_out        : one-cycle pulse, data_out carries a new result
//   data_out         : filtered (or bypassed) sample, held between pulses
interface iir_biquad_cascade_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output valid_in,
        output data_in,
        input  ready_in,
        input  valid_out,
        input  data_out
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output ready_in,
        output valid_out,
        output data_out
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Cascade of NUM_SECTIONS Direct Form I biquads sharing a single multiplier
// and accumulator. Each section takes 5 MAC cycles (b0,b1,b2,a1,a2) plus one
// ROUND cycle, so a sample needs 6*NUM_SECTIONS+1 cycles to reach data_out.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_if (slave)        : valid_in/ready_in/data_in in, valid_out/data_out out
//   bypass              : accepted sample is copied straight to data_out
//   state_clr           : zeroes every delay line, aborts a sample in flight
//   coeff_wr_en/addr/wdata : coefficient write (index 5*section + k)
//   coeff_wr_err        : pulse when a write arrives while busy
//   clr_flags           : clears the sticky overflow/underflow flags
//   overflow, underflow : sticky saturation flags
module iir_biquad_cascade #(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_FRAC    = 15,
    parameter int COEFF_WIDTH  = 20,
    parameter int COEFF_FRAC   = 18,
    parameter int NUM_SECTIONS = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    iir_biquad_cascade_if.slave                    s_if,
    input  logic                                   bypass,
    input  logic                                   state_clr,
    input  logic                                   coeff_wr_en,
    input  logic [$clog2(5*NUM_SECTIONS)-1:0]      coeff_addr,
    input  logic [COEFF_WIDTH-1:0]                 coeff_wdata,
    output logic                                   coeff_wr_err,
    input  logic                                   clr_flags,
    output logic                                   overflow,
    output logic                                   underflow
);
    localparam int ACC_W  = DATA_WIDTH + COEFF_WIDTH + 3;
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int NCOEF  = 5 * NUM_SECTIONS;
    localparam int CAW    = $clog2(NCOEF);
    localparam int SW     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;

    localparam logic signed [ACC_W-1:0]       SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0]       SAT_MIN = ~SAT_MAX;
    localparam logic signed [ACC_W-1:0]       RND_C   = ACC_W'(1) << (COEFF_FRAC - 1);
    localparam logic signed [COEFF_WIDTH-1:0] ONE_C   = COEFF_WIDTH'(1) << COEFF_FRAC;

    // Parameter sanity at elaboration; the data Q-format cancels in the math.
    if (NUM_SECTIONS < 1 || NUM_SECTIONS > 8 || DATA_FRAC >= DATA_WIDTH) begin : g_bad_param
        $error("iir_biquad_cascade: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a rounded accumulator to the sample range: {hi, lo, value}.
    function automatic logic [DATA_WIDTH+1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic [DATA_WIDTH+1:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, 1'b0, DATA_WIDTH'(SAT_MAX)};
        end else if (v < SAT_MIN) begin
            r = {1'b0, 1'b1, DATA_WIDTH'(SAT_MIN)};
        end else begin
            r = {2'b00, DATA_WIDTH'(v)};
        end
        return r;
    endfunction

    state_t                        state_r, state_nx_s;
    logic [SW-1:0]                 sec_r;
    logic [2:0]                    k_r;
    logic signed [DATA_WIDTH-1:0]  cur_x_r;
    logic signed [DATA_WIDTH-1:0]  x1_r [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  x2_r [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y1_r [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y2_r [NUM_SECTIONS];
    logic signed [COEFF_WIDTH-1:0] coeff_r [NCOEF];
    logic signed [ACC_W-1:0]       acc_r;
    logic [DATA_WIDTH-1:0]         data_out_r;
    logic                          valid_out_r, coeff_wr_err_r, overflow_r, underflow_r;

    logic                          idle_s, accept_s, bypass_s, last_sec_s, wr_in_range_s;
    logic [CAW-1:0]                coeff_idx_s;
    logic signed [DATA_WIDTH-1:0]  op_x_s;
    logic signed [COEFF_WIDTH-1:0] op_c_s;
    logic signed [PROD_W-1:0]      prod_s;
    logic signed [ACC_W-1:0]       term_s, acc_nx_s, rnd_s;
    logic [DATA_WIDTH+1:0]         sat_pack_s;
    logic signed [DATA_WIDTH-1:0]  sat_s;
    logic                          sat_hi_s, sat_lo_s;

    assign idle_s        = (state_r == IDLE);
    assign accept_s      = s_if.valid_in && idle_s && !bypass;
    assign bypass_s      = s_if.valid_in && idle_s && bypass;
    assign last_sec_s    = (sec_r == SW'(NUM_SECTIONS - 1));
    assign wr_in_range_s = ({1'b0, coeff_addr} < (CAW + 1)'(NCOEF));
    assign coeff_idx_s   = CAW'(8'(sec_r) * 8'd5 + 8'(k_r));

    assign s_if.ready_in  = idle_s;
    assign s_if.valid_out = valid_out_r;
    assign s_if.data_out  = data_out_r;
    assign coeff_wr_err   = coeff_wr_err_r;
    assign overflow       = overflow_r;
    assign underflow      = underflow_r;

    // Sequencer next state; state_clr always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        if (state_clr) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = accept_s ? MAC : IDLE;
                MAC:     state_nx_s = (k_r == 3'd4) ? ROUND : MAC;
                ROUND:   state_nx_s = last_sec_s ? DONE : MAC;
                DONE:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Shared MAC operand select: k picks x, x1, x2, y1, y2 of the current section.
    always_comb begin
        op_x_s = cur_x_r;
        case (k_r)
            3'd0:    op_x_s = cur_x_r;
            3'd1:    op_x_s = x1_r[sec_r];
            3'd2:    op_x_s = x2_r[sec_r];
            3'd3:    op_x_s = y1_r[sec_r];
            3'd4:    op_x_s = y2_r[sec_r];
            default: op_x_s = cur_x_r;
        endcase
    end

    assign op_c_s = coeff_r[coeff_idx_s];
    assign prod_s = PROD_W'(op_x_s) * PROD_W'(op_c_s);
    assign term_s = ACC_W'(prod_s);

    // Accumulate: k=0 restarts the sum, feedback terms (a1, a2) are subtracted.
    always_comb begin
        acc_nx_s = acc_r;
        if (k_r == 3'd0) begin
            acc_nx_s = term_s;
        end else if (k_r >= 3'd3) begin
            acc_nx_s = acc_r - term_s;
        end else begin
            acc_nx_s = acc_r + term_s;
        end
    end

    assign rnd_s      = (acc_r + RND_C) >>> COEFF_FRAC;
    assign sat_pack_s = saturate(rnd_s);
    assign sat_hi_s   = sat_pack_s[DATA_WIDTH+1];
    assign sat_lo_s   = sat_pack_s[DATA_WIDTH];
    assign sat_s      = sat_pack_s[DATA_WIDTH-1:0];

    // Datapath: sample capture, MAC, section hand-off and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_r       <= '0;
            k_r         <= 3'd0;
            cur_x_r     <= '0;
            acc_r       <= '0;
            data_out_r  <= '0;
            valid_out_r <= 1'b0;
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                x1_r[i] <= '0;
                x2_r[i] <= '0;
                y1_r[i] <= '0;
                y2_r[i] <= '0;
            end
        end else begin
            valid_out_r <= 1'b0;
            if (state_clr) begin
                sec_r <= '0;
                k_r   <= 3'd0;
                for (int i = 0; i < NUM_SECTIONS; i++) begin
                    x1_r[i] <= '0;
                    x2_r[i] <= '0;
                    y1_r[i] <= '0;
                    y2_r[i] <= '0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (accept_s) begin
                            cur_x_r <= $signed(s_if.data_in);
                            sec_r   <= '0;
                            k_r     <= 3'd0;
                        end else if (bypass_s) begin
                            data_out_r  <= s_if.data_in;
                            valid_out_r <= 1'b1;
                        end
                    end
                    MAC: begin
                        acc_r <= acc_nx_s;
                        k_r   <= (k_r == 3'd4) ? 3'd0 : k_r + 3'd1;
                    end
                    ROUND: begin
                        // Delay lines of this section move only here.
                        x2_r[sec_r] <= x1_r[sec_r];
                        x1_r[sec_r] <= cur_x_r;
                        y2_r[sec_r] <= y1_r[sec_r];
                        y1_r[sec_r] <= sat_s;
                        cur_x_r     <= sat_s;
                        sec_r       <= last_sec_s ? '0 : sec_r + SW'(1);
                    end
                    DONE: begin
                        data_out_r  <= cur_x_r;
                        valid_out_r <= 1'b1;
                    end
                    default: begin
                        k_r <= 3'd0;
                    end
                endcase
            end
        end
    end

    // Coefficient bank: writes land only while idle, busy writes are flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_wr_err_r <= 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                coeff_r[i] <= ((i % 5) == 0) ? ONE_C : '0;
            end
        end else begin
            coeff_wr_err_r <= 1'b0;
            if (coeff_wr_en && wr_in_range_s) begin
                if (idle_s) begin
                    coeff_r[coeff_addr] <= coeff_wdata;
                end else begin
                    coeff_wr_err_r <= 1'b1;
                end
            end
        end
    end

    // Sticky saturation flags; clr_flags wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clr_flags) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (state_r == ROUND && !state_clr) begin
            overflow_r  <= overflow_r | sat_hi_s;
            underflow_r <= underflow_r | sat_lo_s;
        end else begin
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed self-checking bench for iir_biquad_cascade (NUM_SECTIONS = 3).
module tb_iir_biquad_cascade;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bypass;
    logic        state_clr;
    logic        coeff_wr_en;
    logic [3:0]  coeff_addr;
    logic [19:0] coeff_wdata;
    logic        coeff_wr_err;
    logic        clr_flags;
    logic        overflow;
    logic        underflow;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    iir_biquad_cascade_if #(.DATA_WIDTH(16)) bus ();

    iir_biquad_cascade #(
        .DATA_WIDTH(16), .DATA_FRAC(15), .COEFF_WIDTH(20),
        .COEFF_FRAC(18), .NUM_SECTIONS(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_if         (bus),
        .bypass       (bypass),
        .state_clr    (state_clr),
        .coeff_wr_en  (coeff_wr_en),
        .coeff_addr   (coeff_addr),
        .coeff_wdata  (coeff_wdata),
        .coeff_wr_err (coeff_wr_err),
        .clr_flags    (clr_flags),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_coeff(input logic [3:0] a, input logic [19:0] d);
        coeff_wr_en = 1'b1;
        coeff_addr  = a;
        coeff_wdata = d;
        cycle();
        coeff_wr_en = 1'b0;
    endtask

    task automatic set_sec0(input logic [19:0] b0, input logic [19:0] b1, input logic [19:0] b2,
                            input logic [19:0] a1, input logic [19:0] a2);
        wr_coeff(4'd0, b0);
        wr_coeff(4'd1, b1);
        wr_coeff(4'd2, b2);
        wr_coeff(4'd3, a1);
        wr_coeff(4'd4, a2);
    endtask

    task automatic clr_state();
        state_clr = 1'b1;
        cycle();
        state_clr = 1'b0;
    endtask

    // Offer one sample and wait (bounded) for valid_out; lat counts cycles after accept.
    task automatic send(input logic [15:0] d, output logic [15:0] got, output int lat);
        got = 16'hxxxx;
        lat = 999;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        cycle();
        bus.valid_in = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (bus.valid_out) begin
                lat = i;
                got = bus.data_out;
                break;
            end
        end
    endtask

    // Start a sample, then let it run n cycles into the computation.
    task automatic start_only(input logic [15:0] d, input int n);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        cycle();
        bus.valid_in = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        chk_cnt++; if (bus.ready_in !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ready_in); else pass_cnt++;
        chk_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid_out); else pass_cnt++;
        chk_cnt++; if (bus.data_out !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", bus.data_out); else pass_cnt++;
        chk_cnt++; if (coeff_wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b expected 0", coeff_wr_err); else pass_cnt++;
        chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {overflow, underflow}); else pass_cnt++;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_identity();
        logic [15:0] got;
        int lat;
        send(16'h4000, got, lat);
        chk_cnt++; if (lat !== 19) $display("FAIL ident_latency: got %0d expected 19", lat); else pass_cnt++;
        chk_cnt++; if (got !== 16'h4000) $display("FAIL ident_data: got %h expected 4000", got); else pass_cnt++;
        chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL ident_flags: got %b expected 00", {overflow, underflow}); else pass_cnt++;
        cycle();
        chk_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL ident_pulse: got %b expected 0", bus.valid_out); else pass_cnt++;
        chk_cnt++; if (bus.data_out !== 16'h4000) $display("FAIL ident_hold: got %h expected 4000", bus.data_out); else pass_cnt++;
        chk_cnt++; if (bus.ready_in !== 1'b1) $display("FAIL ident_ready: got %b expected 1", bus.ready_in); else pass_cnt++;
    endtask

    // Impulse through y = 0.5x + 0.5y1: 0x4000,0,0 -> 0x2000,0x1000,0x0800.
    task automatic impulse_seq(input string tag);
        logic [15:0] got;
        int lat;
        send(16'h4000, got, lat);
        chk_cnt++; if (got !== 16'h2000) $display("FAIL %s_imp0: got %h expected 2000", tag, got); else pass_cnt++;
        send(16'h0000, got, lat);
        chk_cnt++; if (got !== 16'h1000) $display("FAIL %s_imp1: got %h expected 1000", tag, got); else pass_cnt++;
        send(16'h0000, got, lat);
        chk_cnt++; if (got !== 16'h0800) $display("FAIL %s_imp2: got %h expected 0800", tag, got); else pass_cnt++;
    endtask

    task automatic test_impulse();
        set_sec0(20'h20000, 20'h0, 20'h0, 20'hE0000, 20'h0);
        clr_state();
        impulse_seq("impulse");
    endtask

    task automatic test_saturation();
        logic [15:0] got;
        int lat;
        set_sec0(20'h60000, 20'h0, 20'h0, 20'h0, 20'h0);
        clr_state();
        send(16'h7000, got, lat);
        chk_cnt++; if (got !== 16'h7FFF) $display("FAIL sat_hi_data: got %h expected 7fff", got); else pass_cnt++;
        chk_cnt++; if ({overflow, underflow} !== 2'b10) $display("FAIL sat_hi_flags: got %b expected 10", {overflow, underflow}); else pass_cnt++;
        send(16'h8000, got, lat);
        chk_cnt++; if (got !== 16'h8000) $display("FAIL sat_lo_data: got %h expected 8000", got); else pass_cnt++;
        chk_cnt++; if ({overflow, underflow} !== 2'b11) $display("FAIL sat_lo_flags: got %b expected 11", {overflow, underflow}); else pass_cnt++;
        clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;
        chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL sat_clear: got %b expected 00", {overflow, underflow}); else pass_cnt++;
    endtask

    task automatic test_wr_busy();
        logic [15:0] got;
        int lat;
        set_sec0(20'h40000, 20'h0, 20'h0, 20'h0, 20'h0);
        clr_state();
        start_only(16'h4000, 0);
        coeff_wr_en = 1'b1;
        coeff_addr  = 4'd0;
        coeff_wdata = 20'h10000;
        cycle();
        coeff_wr_en = 1'b0;
        chk_cnt++; if (coeff_wr_err !== 1'b1) $display("FAIL wr_busy_err: got %b expected 1", coeff_wr_err); else pass_cnt++;
        cycle();
        chk_cnt++; if (coeff_wr_err !== 1'b0) $display("FAIL wr_busy_pulse: got %b expected 0", coeff_wr_err); else pass_cnt++;
        got = 16'hxxxx;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) begin
                got = bus.data_out;
                break;
            end
            cycle();
        end
        chk_cnt++; if (got !== 16'h4000) $display("FAIL wr_busy_inflight: got %h expected 4000", got); else pass_cnt++;
        cycle();
        wr_coeff(4'd15, 20'h10000);
        chk_cnt++; if (coeff_wr_err !== 1'b0) $display("FAIL wr_range_err: got %b expected 0", coeff_wr_err); else pass_cnt++;
        send(16'h4000, got, lat);
        chk_cnt++; if (got !== 16'h4000) $display("FAIL wr_busy_rerun: got %h expected 4000", got); else pass_cnt++;
        chk_cnt++; if (lat !== 19) $display("FAIL wr_busy_latency: got %0d expected 19", lat); else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [15:0] got;
        int lat;
        set_sec0(20'h20000, 20'h0, 20'h0, 20'hE0000, 20'h0);
        clr_state();
        bypass       = 1'b1;
        bus.valid_in = 1'b1;
        bus.data_in  = 16'h1234;
        cycle();
        bus.valid_in = 1'b0;
        bypass       = 1'b0;
        chk_cnt++; if (bus.valid_out !== 1'b1) $display("FAIL byp_valid: got %b expected 1", bus.valid_out); else pass_cnt++;
        chk_cnt++; if (bus.data_out !== 16'h1234) $display("FAIL byp_data: got %h expected 1234", bus.data_out); else pass_cnt++;
        chk_cnt++; if (bus.ready_in !== 1'b1) $display("FAIL byp_ready: got %b expected 1", bus.ready_in); else pass_cnt++;
        cycle();
        chk_cnt++; if (bus.valid_out !== 1'b0) $display("FAIL byp_pulse: got %b expected 0", bus.valid_out); else pass_cnt++;
        send(16'h4000, got, lat);
        chk_cnt++; if (got !== 16'h2000) $display("FAIL byp_after0: got %h expected 2000", got); else pass_cnt++;
        send(16'h0000, got, lat);
        chk_cnt++; if (got !== 16'h1000) $display("FAIL byp_after1: got %h expected 1000", got); else pass_cnt++;
    endtask

    task automatic watch_no_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.valid_out) seen = 1'b1;
            cycle();
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL %s_no_valid: got %b expected 0", tag, seen); else pass_cnt++;
    endtask

    task automatic test_clear_mid();
        clr_state();
        start_only(16'h4000, 8);
        state_clr = 1'b1;
        cycle();
        state_clr = 1'b0;
        chk_cnt++; if (bus.ready_in !== 1'b1) $display("FAIL clr_ready: got %b expected 1", bus.ready_in); else pass_cnt++;
        watch_no_valid("clr");
        impulse_seq("clr");
    endtask

    task automatic test_reset_mid();
        start_only(16'h4000, 8);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk_cnt++; if (bus.ready_in !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", bus.ready_in); else pass_cnt++;
        chk_cnt++; if (bus.data_out !== 16'h0000) $display("FAIL rst_mid_data: got %h expected 0000", bus.data_out); else pass_cnt++;
        watch_no_valid("rst_mid");
        set_sec0(20'h20000, 20'h0, 20'h0, 20'hE0000, 20'h0);
        impulse_seq("rst_mid");
    endtask

    initial begin
        rst_n        = 1'b0;
        bypass       = 1'b0;
        state_clr    = 1'b0;
        coeff_wr_en  = 1'b0;
        coeff_addr   = 4'd0;
        coeff_wdata  = 20'h0;
        clr_flags    = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 16'h0000;
        test_reset();
        test_identity();
        test_impulse();
        test_saturation();
        test_wr_busy();
        test_bypass();
        test_clear_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/iir_biquad_cascade.md
IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

Interface
REQ-001 Param DATA_WIDTH, default 16, sample width, signed two's complement.
REQ-002 Param DATA_FRAC, default 15, sample fractional bits.
REQ-003 Param COEFF_WIDTH, default 20, coefficient width, signed.
REQ-004 Param COEFF_FRAC, default 18, coefficient fractional bits.
REQ-005 Param NUM_SECTIONS, default 3, number of cascaded biquads; legal range 1..8.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 valid_in  in  1  input sample valid.
REQ-009 ready_in  out  1  block can accept a sample.
REQ-010 data_in  in  DATA_WIDTH  input sample.
REQ-011 bypass  in  1  pass-through mode.
REQ-012 state_clr  in  1  synchronous clear of all delay lines.
REQ-013 coeff_wr_en  in  1  coefficient write strobe.
REQ-014 coeff_addr  in  $clog2(5*NUM_SECTIONS)  coefficient index.
REQ-015 coeff_wdata  in  COEFF_WIDTH  coefficient value.
REQ-016 coeff_wr_err  out  1  one-cycle pulse on a dropped write.
REQ-017 clr_flags  in  1  clears sticky flags.
REQ-018 data_out  out  DATA_WIDTH  filtered sample.
REQ-019 valid_out  out  1  one-cycle pulse, data_out valid.
REQ-020 overflow / underflow  out  1 each  sticky saturation flags.

Function
REQ-021 Each section s SHALL compute Direct Form I: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; section s output is section s+1 input; last section output drives data_out.
REQ-022 Coefficient index SHALL be 5*s+k, k order b0,b1,b2,a1,a2; writes to indices >= 5*NUM_SECTIONS are ignored without error.
REQ-023 One shared multiplier and one accumulator SHALL be time-multiplexed; ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+3.
REQ-024 FSM states IDLE, MAC, ROUND, DONE; IDLE->MAC on valid_in&&ready_in&&!bypass; MAC performs 5 cycles (k=0..4) then ->ROUND; ROUND->MAC of next section, or ->DONE after last section; DONE->IDLE.
REQ-025 ready_in SHALL be 1 only in IDLE; valid_in outside IDLE is ignored.
REQ-026 Latency accept-to-valid_out SHALL be 6*NUM_SECTIONS+1 cycles in filter mode; throughput one sample per 6*NUM_SECTIONS+2 cycles.
REQ-027 ROUND SHALL add 2^(COEFF_FRAC-1) to acc, arithmetic-shift right COEFF_FRAC, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; the saturated value updates y1/y2 and feeds the next section.
REQ-028 Any section saturating high SHALL set overflow, low SHALL set underflow; flags stay set until clr_flags (clr_flags wins over a same-cycle set).
REQ-029 Section delay lines (x1,x2,y1,y2) SHALL shift only in that section's ROUND cycle.
REQ-030 bypass in IDLE with valid_in: data_out=data_in, valid_out pulse next cycle, FSM stays IDLE, delay lines unchanged.
REQ-031 coeff_wr_en SHALL take effect next cycle only in IDLE; in other states the write is dropped and coeff_wr_err pulses next cycle.
REQ-032 state_clr SHALL zero all delay lines and abort any sample in flight (FSM->IDLE, no valid_out); coefficients and flags unchanged.
REQ-033 data_out SHALL hold its last value between valid_out pulses.

Reset
REQ-034 On rst_n low: FSM IDLE, ready_in 1, valid_out 0, data_out 0, coeff_wr_err 0, overflow 0, underflow 0, delay lines 0.
REQ-035 Reset coefficients: b0 = 2^COEFF_FRAC (1.0), b1=b2=a1=a2=0 for every section (identity cascade).
REQ-036 Reset mid-operation SHALL abort the sample with no valid_out after release.

Verification
REQ-037 Post-reset identity: data_in 0x4000 accepted -> valid_out exactly 19 cycles later (NUM_SECTIONS=3), data_out 0x4000, flags 0.
REQ-038 Impulse: section0 b0=0x20000 (0.5), a1=0xE0000 (-0.5), others identity; inputs 0x4000,0,0 -> outputs 0x2000,0x1000,0x0800.
REQ-039 Saturation: section0 b0=0x60000 (1.5); input 0x7000 -> 0x7FFF, overflow=1; input 0x8000 -> 0x8000, underflow=1; clr_flags -> both 0.
REQ-040 Write during MAC -> coeff_wr_err pulse, coefficient unchanged (re-run REQ-037 gives 0x4000).
REQ-041 Bypass: data_in 0x1234 with bypass=1 -> data_out 0x1234 next cycle; following filtered sample unaffected by it.
REQ-042 state_clr or rst_n asserted mid-MAC -> no valid_out, ready_in 1 next cycle, next impulse reproduces REQ-038 sequence.
